quire_to_posit_4_0: RTL and testbench

Pipelined converter that turns the 19-bit two's-complement quire stream produced by the posit<4,0> accumulator into 4-bit posit<4,0> words. It normalizes and rounds the value to nearest, ties to even. It never rounds a nonzero value to zero and saturates at ±maxpos. The block sits directly downstream of the quire on the same rts/rtr/sow/eow stream interface, and feeds posit results back into the dataflow.

---
 rtl/quire_to_posit_4_0.sv | 163 ++++++++++++++++
 tb/tb_quire_to_posit_4_0.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quire_to_posit_4_0.sv
// Three-stage converter from the 19-bit posit<4,0> quire to a 4-bit posit word.
// Stages: magnitude capture, leading-one normalize, round-to-nearest-even encode.
module quire_to_posit_4_0 #(
    parameter bit EOW_ONLY = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        rtr_o,
    input  logic        rts_i,
    input  logic        sow_i,
    input  logic        eow_i,
    input  logic [18:0] data_i,
    input  logic        NaR_i,
    input  logic        sign_i,
    input  logic        zero_i,
    input  logic        rtr_i,
    output logic        rts_o,
    output logic        sow_o,
    output logic        eow_o,
    output logic [3:0]  posit_o,
    output logic        NaR_o,
    output logic        sign_o,
    output logic        zero_o
);

    logic        process_en;
    logic        keep;
    logic [18:0] mag_next;

    logic        v1_reg, nar1_reg, zero1_reg, neg1_reg, sow1_reg, eow1_reg;
    logic [18:0] mag1_reg;

    logic [4:0]  lead_pos;
    logic [18:0] norm;

    logic        v2_reg, nar2_reg, zero2_reg, neg2_reg, sow2_reg, eow2_reg;
    logic [4:0]  pos2_reg;
    logic        b1_reg, b0_reg, sticky_reg;

    logic [3:0]  p_next;
    logic [3:0]  enc_next;

    assign process_en = rtr_i | ~rts_o;
    assign rtr_o      = process_en;

    // With the window filter on, words that do not close a window are consumed silently.
    assign keep     = rts_i & (~EOW_ONLY | eow_i);
    assign mag_next = data_i[18] ? (~data_i + 19'd1) : data_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_reg    <= 1'b0;
            nar1_reg  <= 1'b0;
            zero1_reg <= 1'b0;
            neg1_reg  <= 1'b0;
            sow1_reg  <= 1'b0;
            eow1_reg  <= 1'b0;
            mag1_reg  <= '0;
        end else if (process_en) begin
            v1_reg    <= keep;
            nar1_reg  <= NaR_i;
            zero1_reg <= zero_i;
            neg1_reg  <= data_i[18];
            sow1_reg  <= keep & (EOW_ONLY | sow_i);
            eow1_reg  <= keep & (EOW_ONLY | eow_i);
            mag1_reg  <= mag_next;
        end
    end

    always_comb begin
        lead_pos = '0;
        for (int i = 0; i < 19; i++) begin
            if (mag1_reg[i]) lead_pos = 5'(i);
        end
    end

    // Leading one lands on bit 18; bits 17/16 are the two kept bits, the rest is sticky.
    assign norm = mag1_reg << (5'd18 - lead_pos);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_reg     <= 1'b0;
            nar2_reg   <= 1'b0;
            zero2_reg  <= 1'b0;
            neg2_reg   <= 1'b0;
            sow2_reg   <= 1'b0;
            eow2_reg   <= 1'b0;
            pos2_reg   <= '0;
            b1_reg     <= 1'b0;
            b0_reg     <= 1'b0;
            sticky_reg <= 1'b0;
        end else if (process_en) begin
            v2_reg     <= v1_reg;
            nar2_reg   <= nar1_reg;
            zero2_reg  <= zero1_reg | (mag1_reg == '0);
            neg2_reg   <= neg1_reg;
            sow2_reg   <= sow1_reg;
            eow2_reg   <= eow1_reg;
            pos2_reg   <= lead_pos;
            b1_reg     <= norm[17];
            b0_reg     <= norm[16];
            sticky_reg <= |norm[15:0];
        end
    end

    // Positive patterns sit at 4,8,12,16,24,32,64 sixteenths; midpoints go to the even code.
    always_comb begin
        p_next = 4'd7;
        case (pos2_reg)
            5'd0, 5'd1: p_next = 4'd1;
            5'd2:       p_next = b1_reg ? 4'd2 : 4'd1;
            5'd3: begin
                case ({b1_reg, b0_reg})
                    2'b00:   p_next = 4'd2;
                    2'b01:   p_next = sticky_reg ? 4'd3 : 4'd2;
                    2'b10:   p_next = 4'd3;
                    default: p_next = 4'd4;
                endcase
            end
            5'd4: begin
                case ({b1_reg, b0_reg})
                    2'b00:   p_next = 4'd4;
                    2'b01:   p_next = sticky_reg ? 4'd5 : 4'd4;
                    2'b10:   p_next = 4'd5;
                    default: p_next = 4'd6;
                endcase
            end
            5'd5:    p_next = (b1_reg & (b0_reg | sticky_reg)) ? 4'd7 : 4'd6;
            default: p_next = 4'd7;
        endcase
    end

    always_comb begin
        if (nar2_reg)       enc_next = 4'b1000;
        else if (zero2_reg) enc_next = 4'b0000;
        else if (neg2_reg)  enc_next = ~p_next + 4'd1;
        else                enc_next = p_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rts_o   <= 1'b0;
            sow_o   <= 1'b0;
            eow_o   <= 1'b0;
            posit_o <= 4'b0000;
            NaR_o   <= 1'b0;
            sign_o  <= 1'b0;
            zero_o  <= 1'b0;
        end else if (process_en) begin
            rts_o   <= v2_reg;
            sow_o   <= sow2_reg;
            eow_o   <= eow2_reg;
            posit_o <= enc_next;
            NaR_o   <= nar2_reg;
            sign_o  <= ~nar2_reg & enc_next[3];
            zero_o  <= ~nar2_reg & zero2_reg;
        end
    end

    logic unused_sign;
    assign unused_sign = sign_i;

endmodule

// File: tb/tb_quire_to_posit_4_0.sv
// Bench for quire_to_posit_4_0: one instance per window mode sharing the input stream,
// outputs checked against a nearest-value rounding model.
module tb_quire_to_posit_4_0;

    typedef struct packed {
        logic [3:0] posit;
        logic       nar;
        logic       sign;
        logic       zero;
        logic       sow;
        logic       eow;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rts_i = 1'b0, sow_i = 1'b0, eow_i = 1'b0, nar_i = 1'b0, sign_i = 1'b0, zero_i = 1'b0;
    logic        rtr_i = 1'b1;
    logic [18:0] data_i = '0;

    logic        o0_rtr, o0_rts, o0_sow, o0_eow, o0_nar, o0_sign, o0_zero;
    logic [3:0]  o0_posit;
    logic        o1_rtr, o1_rts, o1_sow, o1_eow, o1_nar, o1_sign, o1_zero;
    logic [3:0]  o1_posit;

    int checks = 0;
    int errors = 0;
    res_t exp0[$], exp1[$], obs0[$], obs1[$];

    always #5 clk = ~clk;

    quire_to_posit_4_0 #(.EOW_ONLY(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .rtr_o(o0_rtr), .rts_i(rts_i), .sow_i(sow_i), .eow_i(eow_i),
        .data_i(data_i), .NaR_i(nar_i), .sign_i(sign_i), .zero_i(zero_i), .rtr_i(rtr_i),
        .rts_o(o0_rts), .sow_o(o0_sow), .eow_o(o0_eow), .posit_o(o0_posit), .NaR_o(o0_nar),
        .sign_o(o0_sign), .zero_o(o0_zero)
    );

    quire_to_posit_4_0 #(.EOW_ONLY(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .rtr_o(o1_rtr), .rts_i(rts_i), .sow_i(sow_i), .eow_i(eow_i),
        .data_i(data_i), .NaR_i(nar_i), .sign_i(sign_i), .zero_i(zero_i), .rtr_i(rtr_i),
        .rts_o(o1_rts), .sow_o(o1_sow), .eow_o(o1_eow), .posit_o(o1_posit), .NaR_o(o1_nar),
        .sign_o(o1_sign), .zero_o(o1_zero)
    );

    // Record a transfer at the negedge preceding the edge on which it happens.
    always @(negedge clk) begin
        if (rst_n && o0_rts && rtr_i)
            obs0.push_back(res_t'({o0_posit, o0_nar, o0_sign, o0_zero, o0_sow, o0_eow}));
        if (rst_n && o1_rts && rtr_i)
            obs1.push_back(res_t'({o1_posit, o1_nar, o1_sign, o1_zero, o1_sow, o1_eow}));
    end

    // Reference: pick the nearest posit<4,0> value, ties to the even code, no zero, saturate.
    function automatic res_t model(input logic [18:0] d, input logic nar, input logic zero,
                                   input logic sow, input logic eow, input logic eow_only);
        res_t r;
        int v, m, dl, dh;
        int c[7];
        int p;
        c = '{4, 8, 12, 16, 24, 32, 64};
        v = d[18] ? int'(d) - 524288 : int'(d);
        m = (v < 0) ? -v : v;
        r.sow = eow_only ? 1'b1 : sow;
        r.eow = eow_only ? 1'b1 : eow;
        r.nar = 1'b0;
        r.zero = 1'b0;
        if (nar) begin
            r.posit = 4'b1000;
            r.nar = 1'b1;
            r.sign = 1'b0;
        end else if (zero || m == 0) begin
            r.posit = 4'b0000;
            r.zero = 1'b1;
            r.sign = 1'b0;
        end else begin
            p = 7;
            if (m <= 4) p = 1;
            else if (m < 64) begin
                for (int k = 0; k < 6; k++) begin
                    if (m > c[k] && m <= c[k+1]) begin
                        dl = m - c[k];
                        dh = c[k+1] - m;
                        if (dl < dh) p = k + 1;
                        else if (dh < dl) p = k + 2;
                        else p = ((k + 1) % 2 == 0) ? k + 1 : k + 2;
                    end
                end
            end
            r.posit = (v < 0) ? 4'(16 - p) : 4'(p);
            r.sign = r.posit[3];
        end
        return r;
    endfunction

    task automatic send(input logic [18:0] d, input logic nar, input logic zero,
                        input logic sow, input logic eow);
        bit acc = 1'b0;
        data_i = d; nar_i = nar; zero_i = zero; sow_i = sow; eow_i = eow;
        sign_i = 1'($urandom);
        rts_i = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = o0_rtr;
            @(posedge clk);
            #1;
        end
        rts_i = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL accept: data %h not accepted within 50 cycles (rtr_o=%b, required 1)", d, o0_rtr);
        end else begin
            exp0.push_back(model(d, nar, zero, sow, eow, 1'b0));
            if (eow) exp1.push_back(model(d, nar, zero, sow, eow, 1'b1));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_queues();
        exp0.delete(); exp1.delete(); obs0.delete(); obs1.delete();
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({o0_rts, o0_sow, o0_eow, o0_nar, o0_sign, o0_zero, o0_posit, o0_rtr} !== 11'b00000000001) begin
            errors++;
            $display("FAIL reset_init: got %b required 00000000001",
                     {o0_rts, o0_sow, o0_eow, o0_nar, o0_sign, o0_zero, o0_posit, o0_rtr});
        end
        idle(2);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) send(19'(16 * (i + 1)), 1'b0, 1'b0, 1'b1, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({o0_rts, o0_sow, o0_eow, o0_nar, o0_sign, o0_zero, o0_posit, o0_rtr} !== 11'b00000000001) begin
            errors++;
            $display("FAIL reset_async0: got %b required 00000000001",
                     {o0_rts, o0_sow, o0_eow, o0_nar, o0_sign, o0_zero, o0_posit, o0_rtr});
        end
        checks++;
        if ({o1_rts, o1_sow, o1_eow, o1_nar, o1_sign, o1_zero, o1_posit, o1_rtr} !== 11'b00000000001) begin
            errors++;
            $display("FAIL reset_async1: got %b required 00000000001",
                     {o1_rts, o1_sow, o1_eow, o1_nar, o1_sign, o1_zero, o1_posit, o1_rtr});
        end
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        clear_queues();
        idle(8);
        checks++;
        if (obs0.size() + obs1.size() != 0) begin
            errors++;
            $display("FAIL reset_stale: got %0d words after reset, required 0", obs0.size() + obs1.size());
        end
        clear_queues();
    endtask

    task automatic test_positive_sweep();
        logic [18:0] vals [8];
        logic [3:0]  want [8];
        vals = '{19'd3, 19'd6, 19'd10, 19'd14, 19'd20, 19'd48, 19'd49, 19'h3FFFF};
        want = '{4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0110, 4'b0111, 4'b0111};
        send(vals[0], 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #2;
        checks++;
        if (o0_rts !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: rts_o %b two edges after input, required 0", o0_rts);
        end
        @(posedge clk); #2;
        checks++;
        if (o0_rts !== 1'b1 || o0_posit !== want[0]) begin
            errors++;
            $display("FAIL latency: rts_o %b posit %b three edges after input, required 1 %b",
                     o0_rts, o0_posit, want[0]);
        end
        for (int i = 1; i < 8; i++) send(vals[i], 1'b0, 1'b0, 1'b0, 1'b0);
        idle(6);
        checks++;
        if (obs0.size() != 8) begin
            errors++;
            $display("FAIL sweep_count: got %0d words, required 8", obs0.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (obs0[i].posit !== want[i] || obs0[i] !== exp0[i]) begin
                    errors++;
                    $display("FAIL sweep[%0d]: data %h got %h required posit %b / %h",
                             i, vals[i], obs0[i], want[i], exp0[i]);
                end
            end
        end
        clear_queues();
    endtask

    task automatic test_negative_and_specials();
        logic [18:0] vals [6];
        logic        nars [6];
        logic        zers [6];
        res_t        want [6];
        vals = '{19'h7FFF0, 19'h7FFFA, 19'h40000, 19'd16, 19'd77, 19'd16};
        nars = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        zers = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        want = '{res_t'(9'b1100_0_1_0_00), res_t'(9'b1110_0_1_0_00), res_t'(9'b1001_0_1_0_00),
                 res_t'(9'b1000_1_0_0_00), res_t'(9'b0000_0_0_1_00), res_t'(9'b1000_1_0_0_00)};
        for (int i = 0; i < 6; i++) send(vals[i], nars[i], zers[i], 1'b0, 1'b0);
        idle(6);
        checks++;
        if (obs0.size() != 6) begin
            errors++;
            $display("FAIL special_count: got %0d words, required 6", obs0.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (obs0[i] !== want[i] || obs0[i] !== exp0[i]) begin
                    errors++;
                    $display("FAIL special[%0d]: data %h got %b required %b", i, vals[i], obs0[i], want[i]);
                end
            end
        end
        clear_queues();
    endtask

    task automatic test_window();
        res_t want;
        want = res_t'(9'b0111_0_0_0_11);
        send(19'd16, 1'b0, 1'b0, 1'b1, 1'b0);
        send(19'd32, 1'b0, 1'b0, 1'b0, 1'b0);
        send(19'd48, 1'b0, 1'b0, 1'b0, 1'b0);
        send(19'd64, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(6);
        checks++;
        if (obs1.size() != 1) begin
            errors++;
            $display("FAIL window_count: got %0d words, required 1", obs1.size());
        end else begin
            checks++;
            if (obs1[0] !== want) begin
                errors++;
                $display("FAIL window_word: got %b required %b", obs1[0], want);
            end
        end
        checks++;
        if (obs0.size() != 4) begin
            errors++;
            $display("FAIL window_passthru: got %0d words, required 4", obs0.size());
        end
        clear_queues();
    endtask

    task automatic test_random();
        logic [18:0] d;
        for (int i = 0; i < 60; i++) begin
            d = ($urandom_range(0, 1) == 0) ? 19'($urandom_range(0, 160)) - 19'd80 : 19'($urandom);
            send(d, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                 1'($urandom), 1'($urandom));
        end
        idle(6);
        checks++;
        if (obs0.size() != exp0.size() || obs1.size() != exp1.size()) begin
            errors++;
            $display("FAIL random_count: got %0d/%0d words, required %0d/%0d",
                     obs0.size(), obs1.size(), exp0.size(), exp1.size());
        end else begin
            foreach (exp0[i]) begin
                checks++;
                if (obs0[i] !== exp0[i]) begin
                    errors++;
                    $display("FAIL random0[%0d]: got %b required %b", i, obs0[i], exp0[i]);
                end
            end
            foreach (exp1[i]) begin
                checks++;
                if (obs1[i] !== exp1[i]) begin
                    errors++;
                    $display("FAIL random1[%0d]: got %b required %b", i, obs1[i], exp1[i]);
                end
            end
        end
        clear_queues();
    endtask

    task automatic test_backpressure();
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(19'(i * 256 + $urandom_range(1, 200)), 1'b0, 1'b0, 1'b0, 1'b0);
            end
            begin
                bit seen = 1'b0;
                for (int t = 0; t < 20 && !seen; t++) begin
                    @(posedge clk); #2;
                    seen = o0_rts;
                end
                checks++;
                if (!seen) begin
                    errors++;
                    $display("FAIL bp_first: rts_o %b within 20 cycles, required 1", o0_rts);
                end
                rtr_i = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(posedge clk); #2;
                    checks++;
                    if (o0_rts !== 1'b1 || o0_rtr !== 1'b0 || exp0.size() == 0 ||
                        res_t'({o0_posit, o0_nar, o0_sign, o0_zero, o0_sow, o0_eow}) !== exp0[0]) begin
                        errors++;
                        $display("FAIL bp_hold[%0d]: rts_o %b rtr_o %b posit %b, required 1 0 %b",
                                 s, o0_rts, o0_rtr, o0_posit, exp0.size() ? exp0[0].posit : 4'bx);
                    end
                end
                rtr_i = 1'b1;
            end
        join
        idle(8);
        checks++;
        if (obs0.size() != 10 || exp0.size() != 10) begin
            errors++;
            $display("FAIL bp_count: got %0d words, required 10", obs0.size());
        end else begin
            foreach (exp0[i]) begin
                checks++;
                if (obs0[i] !== exp0[i]) begin
                    errors++;
                    $display("FAIL bp_order[%0d]: got %b required %b", i, obs0[i], exp0[i]);
                end
            end
        end
        clear_queues();
    endtask

    initial begin
        test_reset();
        test_positive_sweep();
        test_negative_and_specials();
        test_window();
        test_random();
        test_backpressure();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
